// File: rtl/data_mem_unit.sv
// Data-memory stage: one load/store per request, byte/half/word little-endian lanes, optional wait states.
module data_mem_unit #(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = "dmem.hex"
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] DataOut,
  output logic        mem_done,
  output logic        mem_err,
  output logic        mem_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WAIT_CYCLES + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [AW-1:0] idx_r;
  logic [1:0]    lane_r, size_r;
  logic          we_r, uns_r, err_r;
  logic [31:0]   wdata_r;
  logic          accept_s, req_err_s;
  logic [3:0]    wmask_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   mem [DEPTH];

  function automatic logic access_err(input logic [1:0] size, input logic [31:0] a);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = a[0];
      2'b10:   e = (a[1:0] != 2'b00);
      default: e = 1'b1;
    endcase
    return e | ({2'b00, a[31:2]} >= $unsigned(DEPTH));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Narrow store data is replicated so every lane sees its own bits.
  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_err_s = access_err(mem_size, addr);
  assign wmask_s   = lane_mask(size_r, lane_r);
  assign rd_word_s = mem[idx_r];

  // Next-state and wait-counter logic
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (mem_req) begin
          accept_s = 1'b1;
          if ((WAIT_CYCLES > 0) && !req_err_s) begin
            state_s = S_WAIT;
            cnt_s   = CW'(WAIT_CYCLES);
          end else begin
            state_s = S_ACCESS;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_s = S_ACCESS;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_ACCESS: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      idx_r    <= '0;
      lane_r   <= 2'b00;
      size_r   <= 2'b00;
      we_r     <= 1'b0;
      uns_r    <= 1'b0;
      err_r    <= 1'b0;
      wdata_r  <= 32'h0000_0000;
      DataOut  <= 32'h0000_0000;
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      mem_busy <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      mem_busy <= (state_s != S_IDLE);
      mem_done <= (state_r == S_ACCESS);
      mem_err  <= (state_r == S_ACCESS) && err_r;
      if (accept_s) begin
        idx_r   <= addr[AW+1:2];
        lane_r  <= addr[1:0];
        size_r  <= mem_size;
        we_r    <= mem_we;
        uns_r   <= mem_unsigned;
        err_r   <= req_err_s;
        wdata_r <= store_rep(mem_size, wdata);
      end
      if ((state_r == S_ACCESS) && !err_r && !we_r) begin
        DataOut <= load_ext(rd_word_s, size_r, lane_r, uns_r);
      end
    end
  end

  // RAM write port; only a clean ACCESS cycle may write, so a reset abort leaves RAM untouched
  always_ff @(posedge clk) begin
    if (!Reset && (state_r == S_ACCESS) && we_r && !err_r) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) begin
          mem[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

endmodule
